// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: active-low segment
// patterns {g,f,e,d,c,b,a} for hex 0-F and the index-width helper.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;  // lower-case b
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;  // lower-case d
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Digit index width; a single-digit display still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-frame snapshot, blanking
// guard, 4-bit PWM and decimal points. Define SSEG_LZB_EN for leading-zero blanking.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DIV_W     = 16,
    parameter int BLANK_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [3:0]            brightness_i,
    output logic [N_DIGITS-1:0]   sseg_a_o,
    output logic [6:0]            sseg_c_o,
    output logic                  sseg_dp_o,
    output logic                  frame_o
);

    localparam int                IDX_W     = idx_width(N_DIGITS);
    localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(N_DIGITS - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX   = '1;
    localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0]      div_cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  fresh_reg;
    logic [4*N_DIGITS-1:0] snap_dig_reg;
    logic [N_DIGITS-1:0]   snap_dp_reg;

    logic                  slot_wrap;
    logic                  take_snap;
    logic                  lit_now;
    logic [3:0]            pwm_phase;
    logic [4*N_DIGITS-1:0] cur_dig;
    logic [N_DIGITS-1:0]   cur_dp;
    logic [N_DIGITS-1:0]   cur_blank;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blank_sel;
    logic [6:0]            seg_dec;
    logic [N_DIGITS-1:0]   anode_next;
    logic [6:0]            cath_next;
    logic                  dp_next;

    assign slot_wrap = (div_cnt_reg == DIV_MAX);
    // A fresh start (reset or re-enable) snapshots immediately; otherwise only
    // at the slot wrap that closes the rightmost digit.
    assign take_snap = en_i && (fresh_reg || (slot_wrap && idx_reg == '0));

    // While a fresh snapshot is being captured, show the value being captured
    // so the first slot never displays stale data.
    assign cur_dig = fresh_reg ? digits_i : snap_dig_reg;
    assign cur_dp  = fresh_reg ? dp_i     : snap_dp_reg;

`ifdef SSEG_LZB_EN
    logic [N_DIGITS-1:0] live_blank;
    logic [N_DIGITS-1:0] snap_blank_reg;

    // A digit is a leading zero when it and every digit to its left are zero.
    assign live_blank[0] = 1'b0;
    for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lzb
        if (gi == N_DIGITS - 1) begin : g_top
            assign live_blank[gi] = (digits_i[4*gi +: 4] == 4'h0);
        end else begin : g_mid
            assign live_blank[gi] = (digits_i[4*gi +: 4] == 4'h0) && live_blank[gi+1];
        end
    end

    assign cur_blank = fresh_reg ? live_blank : snap_blank_reg;
`else
    assign cur_blank = '0;
`endif

    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                nib_sel   = cur_dig[4*i +: 4];
                dp_sel    = cur_dp[i];
                blank_sel = cur_blank[i];
            end
        end
    end

    sseg_hex_decoder u_dec (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    assign pwm_phase = div_cnt_reg[DIV_W-1 -: 4];
    assign lit_now   = en_i && (div_cnt_reg >= BLANK_END) &&
                       ((brightness_i == 4'hF) || (pwm_phase < brightness_i));

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_anode
        assign anode_next[gi] = !(lit_now && (idx_reg == IDX_W'(gi)));
    end

    assign cath_next = (lit_now && !blank_sel) ? seg_dec : SEG_BLANK;
    assign dp_next   = !(lit_now && dp_sel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg    <= '0;
            idx_reg        <= IDX_TOP;
            fresh_reg      <= 1'b1;
            snap_dig_reg   <= '0;
            snap_dp_reg    <= '0;
`ifdef SSEG_LZB_EN
            snap_blank_reg <= '0;
`endif
            sseg_a_o       <= '1;
            sseg_c_o       <= SEG_BLANK;
            sseg_dp_o      <= 1'b1;
            frame_o        <= 1'b0;
        end else begin
            sseg_a_o  <= anode_next;
            sseg_c_o  <= cath_next;
            sseg_dp_o <= dp_next;
            frame_o   <= take_snap;
            if (!en_i) begin
                div_cnt_reg <= '0;
                idx_reg     <= IDX_TOP;
                fresh_reg   <= 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                fresh_reg   <= 1'b0;
                if (slot_wrap) begin
                    idx_reg <= (idx_reg == '0) ? IDX_TOP : idx_reg - IDX_W'(1);
                end
                if (take_snap) begin
                    snap_dig_reg   <= digits_i;
                    snap_dp_reg    <= dp_i;
`ifdef SSEG_LZB_EN
                    snap_blank_reg <= live_blank;
`endif
                end
            end
        end
    end

endmodule
